mips_mem_stage: RTL and testbench

- Fourth (memory) stage of the 5-stage MIPS pipeline.
- Holds a data RAM addressed by the ALU result and a separate stack RAM addressed by the stack pointer, used by CALL (push) and RET (pop).
- Resolves branch/jump/call/return redirection toward the fetch stage.
- Registers the MEM/WB pipeline values.

---
 rtl/mips_mem_stage_if.sv | 44 ++++
 rtl/mips_mem_stage.sv | 60 ++++++
 tb/tb_mips_mem_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_stage_if.sv
// Signal bundle between the execute-side driver and the MIPS memory stage.
// Inputs flow from master to slave; redirect, forwarding and MEM/WB values flow back.
interface mips_mem_stage_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              BR_Ex;
  logic              JMP_flag;
  logic [15:0]       imm;
  logic              CALL_flag;
  logic              RET_flag;
  logic              Memory_Read;
  logic              Memory_Write;
  logic [DATA_W-1:0] Result;
  logic [ADDR_W-1:0] SP_Data;
  logic [DATA_W-1:0] data1;
  logic [4:0]        Addr_Write_Reg_in;
  logic              Reg_Write_En_in;
  logic              WB_Mux_sel_in;

  logic              BR_JMP_Ex;
  logic [ADDR_W-1:0] next_PC;
  logic [DATA_W-1:0] Mem_out_no_Pipeline;
  logic [DATA_W-1:0] ALU_out_no_Pipeline;
  logic [DATA_W-1:0] Result_out;
  logic [4:0]        Addr_Write_Reg_out;
  logic [DATA_W-1:0] Memory_Data;
  logic              Reg_Write_En_out;
  logic              WB_Mux_sel_out;

  modport master (
    output BR_Ex, JMP_flag, imm, CALL_flag, RET_flag, Memory_Read, Memory_Write,
           Result, SP_Data, data1, Addr_Write_Reg_in, Reg_Write_En_in, WB_Mux_sel_in,
    input  BR_JMP_Ex, next_PC, Mem_out_no_Pipeline, ALU_out_no_Pipeline, Result_out,
           Addr_Write_Reg_out, Memory_Data, Reg_Write_En_out, WB_Mux_sel_out
  );

  modport slave (
    input  BR_Ex, JMP_flag, imm, CALL_flag, RET_flag, Memory_Read, Memory_Write,
           Result, SP_Data, data1, Addr_Write_Reg_in, Reg_Write_En_in, WB_Mux_sel_in,
    output BR_JMP_Ex, next_PC, Mem_out_no_Pipeline, ALU_out_no_Pipeline, Result_out,
           Addr_Write_Reg_out, Memory_Data, Reg_Write_En_out, WB_Mux_sel_out
  );
endinterface

// File: rtl/mips_mem_stage.sv
// MIPS memory stage: data RAM, CALL/RET stack RAM, PC redirect resolution and
// the MEM/WB pipeline register.
module mips_mem_stage #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              reset,
  mips_mem_stage_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  // Contents rely on the power-up zero of the RAM; reset intentionally leaves them intact.
  logic [DATA_W-1:0] stack_ram [DEPTH];
  logic [DATA_W-1:0] data_ram  [DEPTH];

  logic              sel_stack;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] rd_data;
  logic              unused_imm_hi;

  assign sel_stack     = bus.CALL_flag | bus.RET_flag;
  assign data_addr     = bus.Result[ADDR_W-1:0];
  assign unused_imm_hi = ^bus.imm[15:ADDR_W];

  // Asynchronous read: a same-cycle write is not visible until after the edge.
  assign rd_data = sel_stack ? stack_ram[bus.SP_Data] : data_ram[data_addr];

  always_ff @(posedge clk) begin
    if (reset && bus.Memory_Write) begin
      if (sel_stack) begin
        stack_ram[bus.SP_Data] <= bus.data1;
      end else begin
        data_ram[data_addr] <= bus.data1;
      end
    end
  end

  assign bus.Mem_out_no_Pipeline = rd_data;
  assign bus.ALU_out_no_Pipeline = bus.Result;
  assign bus.BR_JMP_Ex = bus.BR_Ex | bus.JMP_flag | bus.CALL_flag | bus.RET_flag;
  // RET wins over CALL for the target; the popped word carries the return address.
  assign bus.next_PC = bus.RET_flag ? rd_data[ADDR_W-1:0] : bus.imm[ADDR_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.Result_out         <= '0;
      bus.Addr_Write_Reg_out <= '0;
      bus.Memory_Data        <= '0;
      bus.Reg_Write_En_out   <= 1'b0;
      bus.WB_Mux_sel_out     <= 1'b0;
    end else begin
      bus.Result_out         <= bus.Result;
      bus.Addr_Write_Reg_out <= bus.Addr_Write_Reg_in;
      bus.Memory_Data        <= bus.Memory_Read ? rd_data : '0;
      bus.Reg_Write_En_out   <= bus.Reg_Write_En_in;
      bus.WB_Mux_sel_out     <= bus.WB_Mux_sel_in;
    end
  end
endmodule

// File: tb/tb_mips_mem_stage.sv
// Self-checking bench for mips_mem_stage: directed tables and sequences plus
// randomized traffic against an array-based memory model.
module tb_mips_mem_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  mips_mem_stage_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  mips_mem_stage #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] stack_m [4096];
  logic [31:0] data_m  [4096];
  logic [31:0] e_result, e_mdata;
  logic [4:0]  e_awr;
  logic        e_rwe, e_wbs;

  typedef struct {
    logic        br, jmp, call, ret;
    logic [15:0] imm;
    logic [11:0] sp;
    logic        exp_bj;
    logic [11:0] exp_pc;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clr();
    bus.BR_Ex = 0; bus.JMP_flag = 0; bus.imm = 0; bus.CALL_flag = 0; bus.RET_flag = 0;
    bus.Memory_Read = 0; bus.Memory_Write = 0; bus.Result = 0; bus.SP_Data = 0;
    bus.data1 = 0; bus.Addr_Write_Reg_in = 0; bus.Reg_Write_En_in = 0; bus.WB_Mux_sel_in = 0;
  endtask

  // Inputs are already applied; checks combinational outputs, then one edge, then registers.
  task automatic cycle_check();
    logic        stack_access;
    logic [31:0] word;
    #1;
    stack_access = bus.CALL_flag || bus.RET_flag;
    word = stack_access ? stack_m[bus.SP_Data] : data_m[bus.Result[11:0]];
    chk("mem_out", bus.Mem_out_no_Pipeline, word);
    chk("alu_out", bus.ALU_out_no_Pipeline, bus.Result);
    chk("br_jmp", {31'b0, bus.BR_JMP_Ex},
        {31'b0, (bus.BR_Ex || bus.JMP_flag || bus.CALL_flag || bus.RET_flag)});
    chk("next_pc", {20'b0, bus.next_PC}, bus.RET_flag ? {20'b0, word[11:0]} : {20'b0, bus.imm[11:0]});
    if (reset) begin
      e_result = bus.Result; e_awr = bus.Addr_Write_Reg_in; e_rwe = bus.Reg_Write_En_in;
      e_wbs = bus.WB_Mux_sel_in; e_mdata = bus.Memory_Read ? word : 32'h0;
      if (bus.Memory_Write) begin
        if (stack_access) stack_m[bus.SP_Data] = bus.data1;
        else data_m[bus.Result[11:0]] = bus.data1;
      end
    end else begin
      e_result = 0; e_awr = 0; e_rwe = 0; e_wbs = 0; e_mdata = 0;
    end
    @(posedge clk); #1;
    chk("result_out", bus.Result_out, e_result);
    chk("awr_out", {27'b0, bus.Addr_Write_Reg_out}, {27'b0, e_awr});
    chk("rwe_out", {31'b0, bus.Reg_Write_En_out}, {31'b0, e_rwe});
    chk("wbs_out", {31'b0, bus.WB_Mux_sel_out}, {31'b0, e_wbs});
    chk("mem_data", bus.Memory_Data, e_mdata);
  endtask

  int unsigned push_sp [5]  = '{200, 201, 202, 203, 204};
  logic [31:0] push_val [5] = '{37, 39, 43, 55, 1};

  initial begin
    for (int i = 0; i < 4096; i++) begin stack_m[i] = 0; data_m[i] = 0; end
    clr();

    // Reset held: registers stay 0 and writes to either RAM are dropped.
    #2;
    bus.Memory_Write = 1; bus.Result = 32'hFFFF_F007; bus.data1 = 32'hBAD0_0001;
    bus.Reg_Write_En_in = 1; bus.WB_Mux_sel_in = 1; bus.Addr_Write_Reg_in = 9; bus.Memory_Read = 1;
    cycle_check();
    chk("rst_result_out", bus.Result_out, 32'h0);
    bus.CALL_flag = 1; bus.SP_Data = 12'd9; bus.data1 = 32'hBAD0_0002;
    cycle_check();
    reset = 1'b1;
    clr(); bus.Memory_Read = 1; bus.Result = 32'd7; #1;
    chk("rst_no_data_write", bus.Mem_out_no_Pipeline, 32'h0);
    bus.RET_flag = 1; bus.SP_Data = 12'd9; #1;
    chk("rst_no_stack_write", bus.Mem_out_no_Pipeline, 32'h0);
    cycle_check();

    // Push five words, then pop them back in reverse order.
    for (int i = 0; i < 5; i++) begin
      clr(); bus.CALL_flag = 1; bus.Memory_Write = 1;
      bus.SP_Data = push_sp[i][11:0]; bus.data1 = push_val[i];
      cycle_check();
    end
    for (int i = 4; i >= 0; i--) begin
      clr(); bus.RET_flag = 1; bus.Memory_Read = 1; bus.SP_Data = push_sp[i][11:0]; #1;
      chk("pop_mem_out", bus.Mem_out_no_Pipeline, push_val[i]);
      chk("pop_next_pc", {20'b0, bus.next_PC}, {20'b0, push_val[i][11:0]});
      chk("pop_br_jmp", {31'b0, bus.BR_JMP_Ex}, 32'd1);
      cycle_check();
      chk("pop_mem_data", bus.Memory_Data, push_val[i]);
    end

    // Data RAM untouched by stack pushes.
    clr(); bus.Memory_Read = 1; bus.Result = 32'd200; #1;
    chk("isolation", bus.Mem_out_no_Pipeline, 32'h0);
    cycle_check();

    // Store then load, and a load with Memory_Read low.
    clr(); bus.Memory_Write = 1; bus.Result = 32'd5; bus.data1 = 32'hDEADBEEF;
    cycle_check();
    clr(); bus.Memory_Read = 1; bus.Result = 32'd5; #1;
    chk("load_mem_out", bus.Mem_out_no_Pipeline, 32'hDEADBEEF);
    cycle_check();
    chk("load_mem_data", bus.Memory_Data, 32'hDEADBEEF);
    clr(); bus.Result = 32'd5;
    cycle_check();
    chk("noread_mem_data", bus.Memory_Data, 32'h0);

    // Read and write together: read shows the old word, write lands.
    clr(); bus.Memory_Read = 1; bus.Memory_Write = 1; bus.Result = 32'd5; bus.data1 = 32'h0BAD_CAFE; #1;
    chk("rw_old_value", bus.Mem_out_no_Pipeline, 32'hDEADBEEF);
    cycle_check();
    chk("rw_mem_data", bus.Memory_Data, 32'hDEADBEEF);
    #1;
    chk("rw_new_value", bus.Mem_out_no_Pipeline, 32'h0BAD_CAFE);

    // Redirect table (stack at 202 holds 43).
    vecs[0] = '{1, 0, 0, 0, 16'h0123, 12'd0,   1, 12'h123};
    vecs[1] = '{0, 1, 0, 0, 16'hF456, 12'd0,   1, 12'h456};
    vecs[2] = '{0, 0, 0, 0, 16'hABCD, 12'd0,   0, 12'hBCD};
    vecs[3] = '{0, 0, 1, 0, 16'h0777, 12'd202, 1, 12'h777};
    vecs[4] = '{0, 0, 1, 1, 16'h0777, 12'd202, 1, 12'd43};
    vecs[5] = '{0, 0, 0, 1, 16'h0FFF, 12'd202, 1, 12'd43};
    for (int i = 0; i < 6; i++) begin
      clr();
      bus.BR_Ex = vecs[i].br; bus.JMP_flag = vecs[i].jmp; bus.CALL_flag = vecs[i].call;
      bus.RET_flag = vecs[i].ret; bus.imm = vecs[i].imm; bus.SP_Data = vecs[i].sp; #1;
      chk($sformatf("vec%0d_br_jmp", i), {31'b0, bus.BR_JMP_Ex}, {31'b0, vecs[i].exp_bj});
      chk($sformatf("vec%0d_next_pc", i), {20'b0, bus.next_PC}, {20'b0, vecs[i].exp_pc});
      cycle_check();
    end

    // Pipeline passthrough, then asynchronous clear mid-cycle.
    clr(); bus.Result = 32'h12345678; bus.Addr_Write_Reg_in = 17;
    bus.Reg_Write_En_in = 1; bus.WB_Mux_sel_in = 1; #1;
    chk("pass_alu_out", bus.ALU_out_no_Pipeline, 32'h12345678);
    cycle_check();
    chk("pass_result_out", bus.Result_out, 32'h12345678);
    chk("pass_awr_out", {27'b0, bus.Addr_Write_Reg_out}, 32'd17);
    #2; reset = 1'b0; #1;
    chk("async_result_out", bus.Result_out, 32'h0);
    chk("async_awr_out", {27'b0, bus.Addr_Write_Reg_out}, 32'd0);
    chk("async_rwe_out", {31'b0, bus.Reg_Write_En_out}, 32'd0);
    chk("async_wbs_out", {31'b0, bus.WB_Mux_sel_out}, 32'd0);
    @(posedge clk); #1; reset = 1'b1;

    // Randomized traffic over a few hot addresses including the wrap edges.
    for (int n = 0; n < 400; n++) begin
      logic [11:0] hot [6];
      hot = '{12'd0, 12'd1, 12'd5, 12'd200, 12'd4094, 12'd4095};
      clr();
      bus.BR_Ex = ($urandom_range(0, 3) == 0);
      bus.JMP_flag = ($urandom_range(0, 5) == 0);
      bus.CALL_flag = ($urandom_range(0, 3) == 0);
      bus.RET_flag = ($urandom_range(0, 3) == 0);
      bus.Memory_Read = $urandom_range(0, 1) == 1;
      bus.Memory_Write = $urandom_range(0, 2) == 0;
      bus.imm = 16'($urandom);
      bus.Result = {20'($urandom), hot[$urandom_range(0, 5)]};
      bus.SP_Data = hot[$urandom_range(0, 5)];
      bus.data1 = $urandom;
      bus.Addr_Write_Reg_in = 5'($urandom);
      bus.Reg_Write_En_in = $urandom_range(0, 1) == 1;
      bus.WB_Mux_sel_in = $urandom_range(0, 1) == 1;
      cycle_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
